// File: rtl/peribus_master.sv
// peribus_master: initiator end of the peripheral bus.
// Takes one load/store request at a time from the core and runs a single
// peribus transaction for it: SETUP -> STROBE -> HOLD, then a one-cycle RESP.
// Optional build macro PERIBUS_IRQ_LATCH_EN: when defined, irq is synchronised,
// edge-detected and held in a sticky irq_pending flag cleared by irq_ack.
// When undefined, irq_pending is a combinational copy of irq.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only in IDLE. While busy the req_* inputs are
// ignored and nothing is queued. resp_valid is a one-cycle pulse (RESP state)
// with no back-pressure; resp_rdata carries the load data during that cycle.
module peribus_master #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  write_enable,
    output logic                  read_enable,
    input  logic                  irq,
    output logic                  irq_pending,
    input  logic                  irq_ack
);

    // Counter is loaded with (phase length - 1), so it needs clog2(longest phase) bits.
    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_C = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYCLES > 0) ? SETUP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'((STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    // State register and all datapath registers; reset aborts any transaction.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; strobes are computed for the next cycle so they come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (SETUP_CYCLES > 0) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = STROBE;
                        cnt_d   = STROBE_LD;
                        we_d    = req_write;
                        re_d    = ~req_write;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                    we_d    = write_q;
                    re_d    = ~write_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    // Last strobe cycle: sample the load data as the strobe drops.
                    if (!write_q) begin
                        rdata_d = read_data;
                    end
                    if (HOLD_CYCLES > 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    we_d  = write_q;
                    re_d  = ~write_q;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign addr         = addr_q;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
    assign read_enable  = re_q;

`ifdef PERIBUS_IRQ_LATCH_EN
    logic sync1_q, sync2_q, prev_q, pend_q;
    logic irq_rise;

    assign irq_rise = sync2_q & ~prev_q;

    // Two-flop synchroniser, edge detector and sticky pending flag (a new edge beats ack).
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pend_q  <= irq_rise | (pend_q & ~irq_ack);
        end
    end

    assign irq_pending = pend_q;
`else
    logic unused_irq_ack;

    assign unused_irq_ack = irq_ack;
    assign irq_pending    = irq;
`endif

endmodule

// File: tb/tb_peribus_master.sv
// Directed bench for peribus_master: default timing instance plus a
// SETUP=0/STROBE=1/HOLD=0 instance, all expectations hand-computed.
module tb_peribus_master;

    logic        clk = 1'b0;
    logic        reset;
    int          total = 0;
    int          bad   = 0;

    // default-timing instance signals
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  addr;
    logic [15:0] write_data, read_data;
    logic        write_enable, read_enable;
    logic        irq, irq_pending, irq_ack;

    // fast instance signals
    logic        f_req_valid, f_req_ready, f_req_write;
    logic [7:0]  f_req_addr;
    logic [15:0] f_req_wdata;
    logic        f_resp_valid;
    logic [15:0] f_resp_rdata;
    logic [7:0]  f_addr;
    logic [15:0] f_write_data, f_read_data;
    logic        f_we, f_re, f_irq_pending;

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    peribus_master dut (
        .CLOCK_50(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .write_enable(write_enable), .read_enable(read_enable),
        .irq(irq), .irq_pending(irq_pending), .irq_ack(irq_ack)
    );

    peribus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0)) dut_fast (
        .CLOCK_50(clk), .reset(reset),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .resp_valid(f_resp_valid), .resp_rdata(f_resp_rdata),
        .addr(f_addr), .write_data(f_write_data), .read_data(f_read_data),
        .write_enable(f_we), .read_enable(f_re),
        .irq(1'b0), .irq_pending(f_irq_pending), .irq_ack(1'b0)
    );

    // advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drive a request to the default instance for the current cycle
    task automatic send(input logic wr, input logic [7:0] a, input logic [15:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
    endtask

    int we_cnt;
    int rv_cnt;

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; read_data = 0;
        irq = 0; irq_ack = 0;
        f_req_valid = 0; f_req_write = 0; f_req_addr = 0; f_req_wdata = 0; f_read_data = 0;
        tick();
        tick();
        // reset state
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", write_data, 0);
        chk("rst_strobes", {write_enable, read_enable}, 0);
        chk("rst_irq_pending", irq_pending, 0);
        reset = 1'b0;
        tick();

        // store, defaults: accepted in cycle 0
        send(1'b1, 8'h05, 16'hAA55);
        tick();  // cycle 1
        req_valid = 1'b0;
        chk("st_c1_addr", addr, 8'h05);
        chk("st_c1_wdata", write_data, 16'hAA55);
        chk("st_c1_ready", req_ready, 0);
        chk("st_c1_we", write_enable, 0);
        tick();  // cycle 2
        chk("st_c2_we", write_enable, 1);
        chk("st_c2_re", read_enable, 0);
        tick();  // cycle 3
        chk("st_c3_we", write_enable, 1);
        tick();  // cycle 4
        chk("st_c4_we", write_enable, 0);
        chk("st_c4_resp", resp_valid, 0);
        chk("st_c4_addr", addr, 8'h05);
        tick();  // cycle 5
        chk("st_c5_resp", resp_valid, 1);
        chk("st_c5_ready", req_ready, 0);
        tick();  // cycle 6
        chk("st_c6_ready", req_ready, 1);
        chk("st_c6_resp", resp_valid, 0);
        chk("st_c6_addr_kept", addr, 8'h05);

        // load: read_data present through STROBE
        read_data = 16'h1234;
        send(1'b0, 8'h00, 16'hFFFF);
        tick();  // cycle 1
        req_valid = 1'b0;
        chk("ld_c1_addr", addr, 8'h00);
        chk("ld_c1_re", read_enable, 0);
        tick();  // cycle 2
        chk("ld_c2_re", read_enable, 1);
        chk("ld_c2_we", write_enable, 0);
        tick();  // cycle 3
        chk("ld_c3_re", read_enable, 1);
        tick();  // cycle 4
        read_data = 16'h0BAD;  // after capture edge; must not reach resp_rdata
        chk("ld_c4_re", read_enable, 0);
        tick();  // cycle 5
        chk("ld_c5_resp", resp_valid, 1);
        chk("ld_c5_rdata", resp_rdata, 16'h1234);
        tick();  // cycle 6

        // busy: store to 05, then a store to 04 held valid during the whole burst
        send(1'b1, 8'h05, 16'h1111);
        we_cnt = 0;
        tick();  // cycle 1
        send(1'b1, 8'h04, 16'h2222);
        for (int c = 1; c <= 5; c++) begin
            chk("busy_ready", req_ready, 0);
            chk("busy_addr", addr, 8'h05);
            if (write_enable) we_cnt++;
            tick();
        end
        // cycle 6: idle again, new request accepted on this edge
        chk("busy_c6_ready", req_ready, 1);
        chk("busy_rdata_kept", resp_rdata, 16'h1234);
        chk("busy_one_burst", we_cnt, 2);
        tick();  // cycle 1 of second request
        req_valid = 1'b0;
        chk("busy2_addr", addr, 8'h04);
        chk("busy2_wdata", write_data, 16'h2222);
        we_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            if (write_enable) we_cnt++;
            tick();
        end
        chk("busy2_one_burst", we_cnt, 2);
        chk("busy2_ready", req_ready, 1);

        // reset mid-strobe
        send(1'b1, 8'h33, 16'h0F0F);
        tick();  // cycle 1
        req_valid = 1'b0;
        tick();  // cycle 2
        chk("rm_c2_we", write_enable, 1);
        reset = 1'b1;
        tick();  // cycle 3
        reset = 1'b0;
        chk("rm_c3_we", write_enable, 0);
        chk("rm_c3_addr", addr, 0);
        chk("rm_c3_wdata", write_data, 0);
        chk("rm_c3_ready", req_ready, 1);
        rv_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid) rv_cnt++;
            tick();
        end
        chk("rm_no_resp", rv_cnt, 0);

        // fast instance: back-to-back load then store
        f_read_data = 16'hBEEF;
        f_req_valid = 1'b1; f_req_write = 1'b0; f_req_addr = 8'h11; f_req_wdata = 16'h0;
        tick();  // cycle 1
        chk("f_c1_re", f_re, 1);
        chk("f_c1_we", f_we, 0);
        chk("f_c1_addr", f_addr, 8'h11);
        chk("f_c1_ready", f_req_ready, 0);
        f_req_write = 1'b1; f_req_addr = 8'h22; f_req_wdata = 16'hCAFE;
        tick();  // cycle 2
        f_read_data = 16'h0000;
        chk("f_c2_resp", f_resp_valid, 1);
        chk("f_c2_rdata", f_resp_rdata, 16'hBEEF);
        chk("f_c2_re", f_re, 0);
        tick();  // cycle 3: store accepted here
        chk("f_c3_ready", f_req_ready, 1);
        chk("f_c3_addr_kept", f_addr, 8'h11);
        tick();  // cycle 4
        f_req_valid = 1'b0;
        chk("f_c4_we", f_we, 1);
        chk("f_c4_re", f_re, 0);
        chk("f_c4_addr", f_addr, 8'h22);
        chk("f_c4_wdata", f_write_data, 16'hCAFE);
        tick();  // cycle 5
        chk("f_c5_resp", f_resp_valid, 1);
        chk("f_c5_we", f_we, 0);
        chk("f_c5_rdata_kept", f_resp_rdata, 16'hBEEF);
        tick();
        chk("f_c6_ready", f_req_ready, 1);

`ifdef PERIBUS_IRQ_LATCH_EN
        // one-cycle irq pulse in cycle 0
        irq = 1'b1;
        tick();  // cycle 1
        irq = 1'b0;
        chk("irq_c1", irq_pending, 0);
        tick();  // cycle 2
        chk("irq_c2", irq_pending, 0);
        tick();  // cycle 3
        chk("irq_c3", irq_pending, 1);
        tick();
        tick();
        chk("irq_sticky", irq_pending, 1);
        irq_ack = 1'b1;
        #1;
        chk("irq_ack_same_cycle", irq_pending, 1);
        tick();
        irq_ack = 1'b0;
        chk("irq_cleared", irq_pending, 0);
`else
        irq = 1'b1;
        #1;
        chk("irq_pass_hi", irq_pending, 1);
        irq_ack = 1'b1;
        tick();
        chk("irq_ack_ignored", irq_pending, 1);
        irq = 1'b0;
        #1;
        chk("irq_pass_lo", irq_pending, 0);
        irq_ack = 1'b0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
